// File: rtl/addsub_signmag_seq_if.sv
// Handshake and data bundle for addsub_signmag_seq.
//   Request side:  in_valid, in_ready, a, b, sub
//   Response side: out_valid, out_ready, mag, neg, cout
//   Status:        busy
// The master modport is the operation source and result consumer.
// The slave modport is the arithmetic block.
interface addsub_signmag_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mag;
    logic             neg;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, mag, neg, cout, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, mag, neg, cout, busy
    );
endinterface

// File: rtl/addsub_signmag_seq.sv
// Multi-cycle unsigned adder/subtractor with a sign-magnitude result.
// Operands are processed CHUNK bits per clock, least-significant chunk
// first. A negative difference gets a second pass that two's-complement
// negates the stored result, so mag always holds |A-B| for subtraction.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of addsub_signmag_seq_if:
//          in_valid/in_ready/a/b/sub  operation request
//          out_valid/out_ready        result handshake
//          mag/neg/cout               result magnitude, sign, first-pass carry
//          busy                       high whenever not idle
module addsub_signmag_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_signmag_seq_if.slave   bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        FIX,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic [WIDTH-1:0] r, r_n;
    logic             carry, carry_n;
    logic [IW-1:0]    idx, idx_n;
    logic             neg_r, neg_n;
    logic             cout_r, cout_n;
    logic [WIDTH-1:0] mag_q;
    logic             neg_q, cout_q;

    logic             accept;
    logic             load_out;
    logic             last;
    int unsigned      shift;
    logic [CHUNK-1:0] a_c, b_c, r_c;
    logic [CHUNK:0]   sum;

    assign shift = 32'(idx) * CHUNK;
    assign last  = (idx == IW'(N - 1));
    assign a_c   = CHUNK'(a_q >> shift);
    assign b_c   = CHUNK'(b_q >> shift);
    assign r_c   = CHUNK'(r >> shift);

    assign accept = (state == IDLE) && bus.in_valid;

    always_comb begin
        state_n  = state;
        r_n      = r;
        carry_n  = carry;
        idx_n    = idx;
        neg_n    = neg_r;
        cout_n   = cout_r;
        sum      = '0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    carry_n = bus.sub;
                    idx_n   = '0;
                    state_n = ADD;
                end
            end
            ADD: begin
                sum     = {1'b0, a_c} + {1'b0, b_c ^ {CHUNK{sub_q}}} + (CHUNK+1)'(carry);
                r_n     = (r & ~(CMASK << shift)) | (WIDTH'(sum[CHUNK-1:0]) << shift);
                carry_n = sum[CHUNK];
                idx_n   = idx + IW'(1);
                if (last) begin
                    cout_n = sum[CHUNK];
                    if (sub_q && !sum[CHUNK]) begin
                        neg_n   = 1'b1;
                        carry_n = 1'b1;
                        idx_n   = '0;
                        state_n = FIX;
                    end else begin
                        neg_n   = 1'b0;
                        state_n = DONE;
                    end
                end
            end
            FIX: begin
                sum     = {1'b0, ~r_c} + (CHUNK+1)'(carry);
                r_n     = (r & ~(CMASK << shift)) | (WIDTH'(sum[CHUNK-1:0]) << shift);
                carry_n = sum[CHUNK];
                idx_n   = idx + IW'(1);
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Visible results are captured only on entry to DONE so they stay put
    // while the next operation rewrites r.
    assign load_out = (state_n == DONE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            r      <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            neg_r  <= 1'b0;
            cout_r <= 1'b0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            state  <= state_n;
            r      <= r_n;
            carry  <= carry_n;
            idx    <= idx_n;
            neg_r  <= neg_n;
            cout_r <= cout_n;
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sub_q <= bus.sub;
            end
            if (load_out) begin
                mag_q  <= r_n;
                neg_q  <= neg_n;
                cout_q <= cout_n;
            end
        end
    end

    // Handshake/status outputs are masked by rst so they read inactive
    // even in the reset cycle before state has returned to IDLE.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE) && !rst;
    assign bus.busy      = (state != IDLE) && !rst;
    assign bus.mag       = mag_q;
    assign bus.neg       = neg_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_addsub_signmag_seq.sv
module tb_addsub_signmag_seq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 2;
    localparam int unsigned N     = WIDTH / CHUNK;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    addsub_signmag_seq_if #(.WIDTH(WIDTH)) bus ();

    addsub_signmag_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned b;
        bit          sub;
        int unsigned mag;
        bit          neg;
        bit          cout;
        int unsigned lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    task automatic model(input int unsigned a, input int unsigned b, input bit sub,
                         output int unsigned mag, output bit neg, output bit cout,
                         output int unsigned lat);
        int unsigned s;
        if (!sub) begin
            s    = a + b;
            mag  = s % (1 << WIDTH);
            cout = (s >= (1 << WIDTH));
            neg  = 1'b0;
            lat  = N;
        end else begin
            neg  = (a < b);
            cout = (a >= b);
            mag  = neg ? (b - a) : (a - b);
            lat  = neg ? 2 * N : N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from a point just after a rising edge.
    // hold: cycles to keep out_ready low in DONE (checking stability).
    // pulse: drive a bogus request during the first busy cycle.
    task automatic run_op(input int unsigned a, input int unsigned b, input bit sub,
                          input int hold, input bit pulse,
                          output int unsigned mag, output bit neg, output bit cout,
                          output int unsigned lat);
        logic [WIDTH-1:0] m0;
        logic             n0, c0;
        chk("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.a         = WIDTH'(a);
        bus.b         = WIDTH'(b);
        bus.sub       = sub;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        if (pulse) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'd1;
            bus.b        = 8'd1;
            bus.sub      = 1'b0;
            chk("in_ready_while_busy", int'(bus.in_ready), 0);
        end
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            bus.in_valid = 1'b0;
            lat++;
        end
        if (!bus.out_valid) chk("result_timeout", 0, 1);
        m0 = bus.mag;
        n0 = bus.neg;
        c0 = bus.cout;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_mag", int'(bus.mag), int'(m0));
            chk("hold_neg", int'(bus.neg), int'(n0));
            chk("hold_cout", int'(bus.cout), int'(c0));
        end
        mag  = bus.mag;
        neg  = bus.neg;
        cout = bus.cout;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_after_handshake", int'(bus.out_valid), 0);
    endtask

    initial begin
        int unsigned gm, gl, em, el;
        bit          gn, gc, en, ec;
        int          extra;

        tests = 0;
        fails = 0;
        vecs[0] = '{200, 100, 1'b0,  44, 1'b0, 1'b1, 4};
        vecs[1] = '{100,  30, 1'b1,  70, 1'b0, 1'b1, 4};
        vecs[2] = '{ 30, 100, 1'b1,  70, 1'b1, 1'b0, 8};
        vecs[3] = '{  0, 255, 1'b1, 255, 1'b1, 1'b0, 8};
        vecs[4] = '{ 55,  55, 1'b1,   0, 1'b0, 1'b1, 4};
        vecs[5] = '{255,   0, 1'b0, 255, 1'b0, 1'b0, 4};
        vecs[6] = '{255, 255, 1'b0, 254, 1'b0, 1'b1, 4};
        vecs[7] = '{  0,   0, 1'b1,   0, 1'b0, 1'b1, 4};
        vecs[8] = '{255,   0, 1'b1, 255, 1'b0, 1'b1, 4};
        vecs[9] = '{  1,   2, 1'b1,   1, 1'b1, 1'b0, 8};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_mag", int'(bus.mag), 0);
        chk("rst_neg", int'(bus.neg), 0);
        chk("rst_cout", int'(bus.cout), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(bus.in_ready), 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, 1'b0, gm, gn, gc, gl);
            chk($sformatf("vec%0d_mag", i), int'(gm), int'(vecs[i].mag));
            chk($sformatf("vec%0d_neg", i), int'(gn), int'(vecs[i].neg));
            chk($sformatf("vec%0d_cout", i), int'(gc), int'(vecs[i].cout));
            chk($sformatf("vec%0d_lat", i), int'(gl), int'(vecs[i].lat));
        end

        // Backpressure on a negative result, with a bogus request mid-flight.
        run_op(30, 100, 1'b1, 3, 1'b1, gm, gn, gc, gl);
        chk("bp_mag", int'(gm), 70);
        chk("bp_neg", int'(gn), 1);
        chk("bp_cout", int'(gc), 0);
        chk("bp_lat", int'(gl), 8);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid || bus.busy) extra++;
            tick();
        end
        chk("no_second_result", extra, 0);

        // Bogus request during an add, result must be unaffected.
        run_op(200, 100, 1'b0, 0, 1'b1, gm, gn, gc, gl);
        chk("busy_pulse_mag", int'(gm), 44);
        chk("busy_pulse_lat", int'(gl), 4);

        // Reset while negating.
        bus.in_valid = 1'b1;
        bus.a        = 8'd30;
        bus.b        = 8'd100;
        bus.sub      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("fix_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", int'(bus.in_ready), 1);
        chk("postrst_out_valid", int'(bus.out_valid), 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) extra++;
            tick();
        end
        chk("aborted_no_result", extra, 0);
        run_op(3, 4, 1'b0, 0, 1'b0, gm, gn, gc, gl);
        chk("after_rst_mag", int'(gm), 7);
        chk("after_rst_lat", int'(gl), 4);
        chk("after_rst_cout", int'(gc), 0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            int unsigned ra, rb;
            bit          rs;
            ra = $urandom_range(255, 0);
            rb = $urandom_range(255, 0);
            rs = 1'($urandom_range(1, 0));
            model(ra, rb, rs, em, en, ec, el);
            run_op(ra, rb, rs, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
                   gm, gn, gc, gl);
            chk($sformatf("rnd%0d_mag(%0d,%0d,%0d)", i, ra, rb, rs), int'(gm), int'(em));
            chk($sformatf("rnd%0d_neg", i), int'(gn), int'(en));
            chk($sformatf("rnd%0d_cout", i), int'(gc), int'(ec));
            chk($sformatf("rnd%0d_lat", i), int'(gl), int'(el));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
